uart_arbiter: RTL and testbench
===============================

UART_ARBITER -- requirements
Module: uart_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_CPU, default 3, number of CPU ports; DATA_W, default 8, UART data width; ADDR_W, default 2, UART register address width; MODE, default 0, 0 = software select, 1 = round-robin.
REQ-002 Derived width SHALL be IDX_W = max(1, clog2(NUM_CPU)).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 Port: clk  in  1  sole clock, rising edge.
REQ-005 Port: rst  in  1  asynchronous active-low reset.
REQ-006 Port: sel_num  in  IDX_W  CPU index allowed to access the UART; used in MODE 0 only.
REQ-007 Port: cpu_rd  in  NUM_CPU  per-CPU read strobe, 1 cycle.
REQ-008 Port: cpu_wr  in  NUM_CPU  per-CPU write strobe, 1 cycle.
REQ-009 Port: cpu_addr  in  NUM_CPU*ADDR_W  per-CPU address, slice i = CPU i.
REQ-010 Port: cpu_dat_o  in  NUM_CPU*DATA_W  per-CPU write data.
REQ-011 Port: cpu_dat_i  out  NUM_CPU*DATA_W  per-CPU read data, held until the next read by that CPU.
REQ-012 Port: cpu_ack  out  NUM_CPU  1-cycle completion pulse per CPU.
REQ-013 Port: cpu_busy  out  NUM_CPU  request pending for that CPU.
REQ-014 Port: uart_rd  out  1  UART read strobe.
REQ-015 Port: uart_wr  out  1  UART write strobe.
REQ-016 Port: uart_addr  out  ADDR_W  UART register address.
REQ-017 Port: uart_din  out  DATA_W  UART write data.
REQ-018 Port: uart_dout  in  DATA_W  UART read data, valid the cycle after uart_rd.
REQ-019 Port: grant_idx  out  IDX_W  index of the CPU currently being served.

Function
REQ-020 Capture: a strobe on CPU i while cpu_busy[i]=0 SHALL latch op, addr and data at the clock edge, and cpu_busy[i] SHALL be 1 from the next cycle.
REQ-021 Strobes on CPU i while cpu_busy[i]=1 SHALL be ignored, with no state change.
REQ-022 When cpu_rd[i] and cpu_wr[i] are asserted in the same cycle, the write SHALL be captured and the read dropped.
REQ-023 FSM states SHALL be IDLE, ISSUE and RESP.
REQ-024 IDLE -> ISSUE SHALL occur when an eligible pending CPU exists; the winner is registered into grant_idx.
REQ-025 ISSUE SHALL drive exactly one uart_rd or uart_wr pulse with the latched addr/data, then go to RESP.
REQ-026 RESP SHALL, for reads, register uart_dout into slice grant_idx of cpu_dat_i.
REQ-027 At the end of RESP, cpu_ack[grant_idx] SHALL pulse for the next cycle, cpu_busy[grant_idx] SHALL clear in that same cycle, and the FSM SHALL go to IDLE.
REQ-028 Latency: a strobe at cycle T SHALL give the UART strobe at T+2 and cpu_ack at T+4 when uncontended; throughput is one transaction per 3 cycles.
REQ-029 Selection SHALL be evaluated only in IDLE; the winner's latched request is stable until its ack.
REQ-030 MODE 0: only CPU sel_num is eligible, and sel_num is sampled in IDLE only.
REQ-031 MODE 0: sel_num >= NUM_CPU SHALL grant nobody.
REQ-032 MODE 0: pending requests of other CPUs SHALL stay pending indefinitely.
REQ-033 MODE 1: the winner SHALL be the first pending CPU searching upward from last_grant+1, wrapping from NUM_CPU-1 to 0.
REQ-034 MODE 1: a changing sel_num SHALL have no effect.
REQ-035 Outside ISSUE, uart_rd, uart_wr, uart_addr and uart_din SHALL be 0.
REQ-036 A strobe from the CPU being acked in the ack cycle SHALL be captured, since busy is 0 in that cycle.

Reset
REQ-037 Asserting rst SHALL asynchronously force: FSM = IDLE; cpu_busy, cpu_ack, uart_rd, uart_wr, uart_addr, uart_din, grant_idx and cpu_dat_i = 0; last_grant = NUM_CPU-1.
REQ-038 Reset mid-transaction SHALL discard all pending requests and produce no ack.
REQ-039 Reset deassertion SHALL be synchronised internally; the first capture is possible on the second edge after release.

Verification (NUM_CPU=3, DATA_W=8, ADDR_W=2)
REQ-040 MODE 0, sel_num=1: CPU1 wr addr 0 data 0x5A at T -> uart_wr=1, uart_addr=0, uart_din=0x5A at T+2; cpu_ack[1] at T+4.
REQ-041 MODE 0, sel_num=1: CPU1 rd addr 2, uart_dout=0xC3 at T+3 -> cpu_dat_i[15:8]=0xC3 and cpu_ack[1] at T+4; other slices remain 0.
REQ-042 MODE 0, sel_num=0, CPU2 wr pending -> no UART activity for 20 cycles, cpu_busy[2]=1; then sel_num=2 -> CPU2 served.
REQ-043 MODE 1: all three CPUs strobe in the same cycle -> grant order 0,1,2 and acks at T+4, T+7, T+10; CPU0 re-request served after CPU2.
REQ-044 Simultaneous rd+wr on CPU0 -> only uart_wr pulses; a second strobe while busy -> no extra transaction.
REQ-045 rst low during ISSUE of a CPU1 read -> outputs 0 immediately; after release, no ack and cpu_busy=0.

Source files
------------

// File: rtl/uart_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_arbiter
// Purpose  : Shares one UART register port among NUM_CPU CPU ports using
//            software-selected or round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module uart_arbiter #(
    parameter int NUM_CPU = 3,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 2,
    parameter int MODE    = 0,
    localparam int IDX_W  = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IDX_W-1:0]          sel_num,
    input  logic [NUM_CPU-1:0]        cpu_rd,
    input  logic [NUM_CPU-1:0]        cpu_wr,
    input  logic [NUM_CPU*ADDR_W-1:0] cpu_addr,
    input  logic [NUM_CPU*DATA_W-1:0] cpu_dat_o,
    output logic [NUM_CPU*DATA_W-1:0] cpu_dat_i,
    output logic [NUM_CPU-1:0]        cpu_ack,
    output logic [NUM_CPU-1:0]        cpu_busy,
    output logic                      uart_rd,
    output logic                      uart_wr,
    output logic [ADDR_W-1:0]         uart_addr,
    output logic [DATA_W-1:0]         uart_din,
    input  logic [DATA_W-1:0]         uart_dout,
    output logic [IDX_W-1:0]          grant_idx
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                    r_state;
    logic                      r_run;
    logic [NUM_CPU-1:0]        r_busy;
    logic [NUM_CPU-1:0]        r_ack;
    logic [NUM_CPU-1:0]        r_op_wr;
    logic [ADDR_W-1:0]         r_addr [NUM_CPU];
    logic [DATA_W-1:0]         r_data [NUM_CPU];
    logic [NUM_CPU*DATA_W-1:0] r_dat_i;
    logic                      r_uart_rd;
    logic                      r_uart_wr;
    logic [ADDR_W-1:0]         r_uart_addr;
    logic [DATA_W-1:0]         r_uart_din;
    logic [IDX_W-1:0]          r_grant;
    logic [IDX_W-1:0]          r_last_grant;

    logic                      w_rr_found;
    logic [IDX_W-1:0]          w_rr_idx;
    int                        w_dist;
    int                        w_best;
    logic                      w_sel_ok;
    logic                      w_found;
    logic [IDX_W-1:0]          w_win;

    // Round-robin: smallest forward distance from last_grant+1 wins.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_best     = NUM_CPU;
        w_dist     = 0;
        for (int i = 0; i < NUM_CPU; i++) begin
            if (r_busy[i]) begin
                w_dist = (i + 2 * NUM_CPU - 1 - int'(r_last_grant)) % NUM_CPU;
                if (w_dist < w_best) begin
                    w_best     = w_dist;
                    w_rr_idx   = IDX_W'(i);
                    w_rr_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_sel_ok = (int'(sel_num) < NUM_CPU) && r_busy[sel_num];
        if (MODE == 0) begin
            w_found = w_sel_ok;
            w_win   = sel_num;
        end else begin
            w_found = w_rr_found;
            w_win   = w_rr_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_run        <= 1'b0;
            r_busy       <= '0;
            r_ack        <= '0;
            r_op_wr      <= '0;
            r_dat_i      <= '0;
            r_uart_rd    <= 1'b0;
            r_uart_wr    <= 1'b0;
            r_uart_addr  <= '0;
            r_uart_din   <= '0;
            r_grant      <= '0;
            r_last_grant <= IDX_W'(NUM_CPU - 1);
            for (int i = 0; i < NUM_CPU; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            // Captures are held off until the first edge after release has passed.
            r_run <= 1'b1;
            r_ack <= '0;
            for (int i = 0; i < NUM_CPU; i++) begin
                if (r_run && !r_busy[i] && (cpu_rd[i] || cpu_wr[i])) begin
                    r_busy[i]  <= 1'b1;
                    r_op_wr[i] <= cpu_wr[i];
                    r_addr[i]  <= cpu_addr[i*ADDR_W +: ADDR_W];
                    r_data[i]  <= cpu_dat_o[i*DATA_W +: DATA_W];
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant      <= w_win;
                        r_last_grant <= w_win;
                        r_uart_rd    <= ~r_op_wr[w_win];
                        r_uart_wr    <= r_op_wr[w_win];
                        r_uart_addr  <= r_addr[w_win];
                        r_uart_din   <= r_op_wr[w_win] ? r_data[w_win] : '0;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_uart_rd   <= 1'b0;
                    r_uart_wr   <= 1'b0;
                    r_uart_addr <= '0;
                    r_uart_din  <= '0;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    for (int i = 0; i < NUM_CPU; i++) begin
                        if (r_grant == IDX_W'(i)) begin
                            r_ack[i]  <= 1'b1;
                            r_busy[i] <= 1'b0;
                            if (!r_op_wr[i]) begin
                                r_dat_i[i*DATA_W +: DATA_W] <= uart_dout;
                            end
                        end
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cpu_dat_i = r_dat_i;
    assign cpu_ack   = r_ack;
    assign cpu_busy  = r_busy;
    assign uart_rd   = r_uart_rd;
    assign uart_wr   = r_uart_wr;
    assign uart_addr = r_uart_addr;
    assign uart_din  = r_uart_din;
    assign grant_idx = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_uart_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_arbiter
// Purpose  : Directed self-checking bench; one MODE 0 and one MODE 1 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  sel_num;
    logic [2:0]  cpu_rd;
    logic [2:0]  cpu_wr;
    logic [5:0]  cpu_addr;
    logic [23:0] cpu_dat_o;
    logic [7:0]  uart_dout;

    logic [23:0] dat_i_m0, dat_i_m1;
    logic [2:0]  ack_m0, ack_m1, busy_m0, busy_m1;
    logic        urd_m0, urd_m1, uwr_m0, uwr_m1;
    logic [1:0]  uaddr_m0, uaddr_m1, grant_m0, grant_m1;
    logic [7:0]  udin_m0, udin_m1;

    int errors = 0;
    int checks = 0;

    uart_arbiter #(.NUM_CPU(3), .DATA_W(8), .ADDR_W(2), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .sel_num(sel_num), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_dat_o(cpu_dat_o), .cpu_dat_i(dat_i_m0),
        .cpu_ack(ack_m0), .cpu_busy(busy_m0), .uart_rd(urd_m0), .uart_wr(uwr_m0),
        .uart_addr(uaddr_m0), .uart_din(udin_m0), .uart_dout(uart_dout),
        .grant_idx(grant_m0)
    );

    uart_arbiter #(.NUM_CPU(3), .DATA_W(8), .ADDR_W(2), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .sel_num(sel_num), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_dat_o(cpu_dat_o), .cpu_dat_i(dat_i_m1),
        .cpu_ack(ack_m1), .cpu_busy(busy_m1), .uart_rd(urd_m1), .uart_wr(uwr_m1),
        .uart_addr(uaddr_m1), .uart_din(udin_m1), .uart_dout(uart_dout),
        .grant_idx(grant_m1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_rd    = '0;
        cpu_wr    = '0;
        cpu_addr  = '0;
        cpu_dat_o = '0;
    endtask

    task automatic drain();
        idle_inputs();
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_reset();
        logic [7:0] zero_flags;
        rst = 1'b0;
        sel_num = 2'd0;
        uart_dout = '0;
        idle_inputs();
        tick();
        tick();
        zero_flags = {|dat_i_m0, |ack_m0, |busy_m0, urd_m0, uwr_m0, |uaddr_m0, |udin_m0, |grant_m0};
        checks++;
        if (zero_flags !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs_m0: nonzero flags %b, want 00000000", zero_flags);
        end
        zero_flags = {|dat_i_m1, |ack_m1, |busy_m1, urd_m1, uwr_m1, |uaddr_m1, |udin_m1, |grant_m1};
        checks++;
        if (zero_flags !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs_m1: nonzero flags %b, want 00000000", zero_flags);
        end
        // Strobe in the release cycle lands on the first edge: must be ignored.
        rst = 1'b1;
        cpu_wr = 3'b001;
        tick();
        idle_inputs();
        checks++;
        if (busy_m0 !== 3'b000 || busy_m1 !== 3'b000) begin
            errors++;
            $display("FAIL reset_first_edge: busy m0=%b m1=%b, want 000", busy_m0, busy_m1);
        end
        cpu_wr = 3'b001;
        tick();
        idle_inputs();
        checks++;
        if (busy_m0 !== 3'b001) begin
            errors++;
            $display("FAIL reset_second_edge: busy %b, want 001", busy_m0);
        end
        drain();
    endtask

    task automatic test_mode0_write();
        sel_num = 2'd1;
        cpu_wr = 3'b010;
        cpu_addr = 6'b000000;
        cpu_dat_o = 24'h005A00;
        tick();
        idle_inputs();
        checks++;
        if (busy_m0 !== 3'b010 || uwr_m0 !== 1'b0) begin
            errors++;
            $display("FAIL wr_t1: busy %b uart_wr %b, want 010 0", busy_m0, uwr_m0);
        end
        tick();
        checks++;
        if ({uwr_m0, urd_m0, uaddr_m0, udin_m0, grant_m0} !== {1'b1, 1'b0, 2'd0, 8'h5A, 2'd1}) begin
            errors++;
            $display("FAIL wr_t2: wr %b rd %b addr %0d din %h grant %0d, want 1 0 0 5a 1",
                     uwr_m0, urd_m0, uaddr_m0, udin_m0, grant_m0);
        end
        tick();
        checks++;
        if ({uwr_m0, udin_m0, ack_m0} !== {1'b0, 8'h00, 3'b000}) begin
            errors++;
            $display("FAIL wr_t3: wr %b din %h ack %b, want 0 00 000", uwr_m0, udin_m0, ack_m0);
        end
        tick();
        checks++;
        if (ack_m0 !== 3'b010 || busy_m0 !== 3'b000) begin
            errors++;
            $display("FAIL wr_t4: ack %b busy %b, want 010 000", ack_m0, busy_m0);
        end
        tick();
        checks++;
        if (ack_m0 !== 3'b000) begin
            errors++;
            $display("FAIL wr_t5: ack %b, want 000", ack_m0);
        end
        drain();
    endtask

    task automatic test_mode0_read();
        sel_num = 2'd1;
        cpu_rd = 3'b010;
        cpu_addr = 6'b001000;
        tick();
        idle_inputs();
        tick();
        checks++;
        if ({urd_m0, uwr_m0, uaddr_m0} !== {1'b1, 1'b0, 2'd2}) begin
            errors++;
            $display("FAIL rd_t2: rd %b wr %b addr %0d, want 1 0 2", urd_m0, uwr_m0, uaddr_m0);
        end
        tick();
        uart_dout = 8'hC3;
        tick();
        uart_dout = 8'h00;
        checks++;
        if (dat_i_m0 !== 24'h00C300 || ack_m0 !== 3'b010) begin
            errors++;
            $display("FAIL rd_t4: dat_i %h ack %b, want 00c300 010", dat_i_m0, ack_m0);
        end
        drain();
        checks++;
        if (dat_i_m0 !== 24'h00C300) begin
            errors++;
            $display("FAIL rd_hold: dat_i %h, want 00c300", dat_i_m0);
        end
    endtask

    task automatic test_mode0_blocked();
        int activity;
        activity = 0;
        sel_num = 2'd3;
        cpu_wr = 3'b100;
        cpu_addr = 6'b110000;
        cpu_dat_o = 24'h770000;
        tick();
        idle_inputs();
        for (int i = 0; i < 20; i++) begin
            if (i == 10) sel_num = 2'd0;
            tick();
            if (urd_m0 || uwr_m0) activity++;
        end
        checks++;
        if (activity !== 0 || busy_m0 !== 3'b100) begin
            errors++;
            $display("FAIL blocked: uart strobes %0d busy %b, want 0 100", activity, busy_m0);
        end
        sel_num = 2'd2;
        tick();
        checks++;
        if ({uwr_m0, uaddr_m0, udin_m0, grant_m0} !== {1'b1, 2'd3, 8'h77, 2'd2}) begin
            errors++;
            $display("FAIL unblocked_issue: wr %b addr %0d din %h grant %0d, want 1 3 77 2",
                     uwr_m0, uaddr_m0, udin_m0, grant_m0);
        end
        tick();
        tick();
        checks++;
        if (ack_m0 !== 3'b100 || busy_m0 !== 3'b000) begin
            errors++;
            $display("FAIL unblocked_ack: ack %b busy %b, want 100 000", ack_m0, busy_m0);
        end
        drain();
    endtask

    task automatic test_round_robin();
        logic       exp_wr;
        logic [1:0] exp_grant;
        logic [7:0] exp_din;
        logic [2:0] exp_ack;
        cpu_wr = 3'b111;
        cpu_addr = 6'b111001;
        cpu_dat_o = 24'h322110;
        for (int t = 1; t <= 13; t++) begin
            tick();
            sel_num = 2'($urandom_range(0, 3));
            if (t == 4) begin
                cpu_wr = 3'b001;
                cpu_addr = 6'b000000;
                cpu_dat_o = 24'h00004B;
            end else begin
                idle_inputs();
            end
            exp_wr = (t == 2) || (t == 5) || (t == 8) || (t == 11);
            case (t)
                2:       begin exp_grant = 2'd0; exp_din = 8'h10; end
                5:       begin exp_grant = 2'd1; exp_din = 8'h21; end
                8:       begin exp_grant = 2'd2; exp_din = 8'h32; end
                default: begin exp_grant = 2'd0; exp_din = 8'h4B; end
            endcase
            case (t)
                4:       exp_ack = 3'b001;
                7:       exp_ack = 3'b010;
                10:      exp_ack = 3'b100;
                13:      exp_ack = 3'b001;
                default: exp_ack = 3'b000;
            endcase
            checks++;
            if (uwr_m1 !== exp_wr || ack_m1 !== exp_ack) begin
                errors++;
                $display("FAIL rr_t%0d: wr %b ack %b, want %b %b", t, uwr_m1, ack_m1, exp_wr, exp_ack);
            end
            if (exp_wr) begin
                checks++;
                if (grant_m1 !== exp_grant || udin_m1 !== exp_din) begin
                    errors++;
                    $display("FAIL rr_grant_t%0d: grant %0d din %h, want %0d %h",
                             t, grant_m1, udin_m1, exp_grant, exp_din);
                end
            end
        end
        drain();
    endtask

    task automatic test_back_to_back_busy();
        int strobes;
        int acks;
        strobes = 0;
        acks = 0;
        sel_num = 2'd0;
        cpu_rd = 3'b001;
        cpu_wr = 3'b001;
        cpu_addr = 6'b000001;
        cpu_dat_o = 24'h0000A5;
        tick();
        cpu_rd = 3'b001;
        cpu_wr = 3'b000;
        cpu_addr = 6'b000011;
        cpu_dat_o = 24'h0000FF;
        tick();
        idle_inputs();
        checks++;
        if ({uwr_m0, urd_m0, uaddr_m0, udin_m0} !== {1'b1, 1'b0, 2'd1, 8'hA5}) begin
            errors++;
            $display("FAIL rdwr_issue: wr %b rd %b addr %0d din %h, want 1 0 1 a5",
                     uwr_m0, urd_m0, uaddr_m0, udin_m0);
        end
        for (int i = 0; i < 9; i++) begin
            if (urd_m0 || uwr_m0) strobes++;
            if (ack_m0 != 3'b000) acks++;
            tick();
        end
        checks++;
        if (strobes !== 1 || acks !== 1) begin
            errors++;
            $display("FAIL busy_ignore: uart strobes %0d acks %0d, want 1 1", strobes, acks);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int acks;
        acks = 0;
        sel_num = 2'd1;
        cpu_rd = 3'b010;
        cpu_addr = 6'b000100;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (urd_m0 !== 1'b1 || grant_m0 !== 2'd1) begin
            errors++;
            $display("FAIL rstmid_issue: rd %b grant %0d, want 1 1", urd_m0, grant_m0);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({urd_m0, uwr_m0, uaddr_m0, udin_m0, grant_m0, busy_m0, dat_i_m0} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: rd %b addr %0d grant %0d busy %b dat_i %h, want all 0",
                     urd_m0, uaddr_m0, grant_m0, busy_m0, dat_i_m0);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ack_m0 != 3'b000) acks++;
        end
        checks++;
        if (acks !== 0 || busy_m0 !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_after: acks %0d busy %b, want 0 000", acks, busy_m0);
        end
    endtask

    initial begin
        test_reset();
        test_mode0_write();
        test_mode0_read();
        test_mode0_blocked();
        test_round_robin();
        test_back_to_back_busy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
